// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-lamp driver: mode codes and the lamp pattern function.
package tail_light_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_BRAKE  = 2'b01;
    localparam logic [1:0] MODE_TURN   = 2'b10;
    localparam logic [1:0] MODE_HAZARD = 2'b11;

    // Returns an 8-bit pattern; callers keep only the low led_n bits.
    function automatic logic [7:0] pattern(input logic [1:0] m, input int unsigned s,
                                           input int unsigned led_n);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            unique case (m)
                MODE_BRAKE:  p[i] = (i < led_n);
                MODE_TURN:   p[i] = (i < led_n) && (s < led_n) && (i <= s);
                MODE_HAZARD: p[i] = (i < led_n) && (s == 0);
                default:     p[i] = 1'b0;
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one wrap pulse every TICK_DIV cycles; clear restarts the count.
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic wrap
);

    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] r_div_cnt;

    assign wrap = (r_div_cnt == W'(TICK_DIV - 1)) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (clear || wrap) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + W'(1);
        end
    end

endmodule

// File: rtl/tail_light_driver.sv
// Tail-lamp LED bar driver: steady brake, sequential turn sweep and hazard blink,
// all timed from clk through tick_prescaler.
module tail_light_driver
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int LED_N    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    output logic [LED_N-1:0] leds,
    output logic             tick
);

    localparam int SW = $clog2(LED_N + 1);

    logic [1:0]       r_mode_q;
    logic [SW-1:0]    r_step;
    logic [LED_N-1:0] r_leds;
    logic             r_tick;

    logic             w_chg;
    logic             w_wrap;
    logic [SW-1:0]    w_step_nxt;
    logic [LED_N-1:0] w_pat_chg;
    logic [LED_N-1:0] w_pat_step;

    assign w_chg = (mode != r_mode_q);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clear (w_chg),
        .wrap  (w_wrap)
    );

    always_comb begin
        w_step_nxt = '0;
        case (r_mode_q)
            MODE_TURN:   w_step_nxt = (r_step == SW'(LED_N)) ? '0 : r_step + SW'(1);
            MODE_HAZARD: w_step_nxt = (r_step == '0) ? SW'(1) : '0;
            default:     w_step_nxt = '0;
        endcase
    end

    assign w_pat_chg  = LED_N'(pattern(mode, 0, LED_N));
    assign w_pat_step = LED_N'(pattern(r_mode_q, 32'(w_step_nxt), LED_N));

    // A mode change wins over a coincident step boundary (wrap is already masked by clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q <= MODE_OFF;
            r_step   <= '0;
            r_leds   <= '0;
            r_tick   <= 1'b0;
        end else if (w_chg) begin
            r_mode_q <= mode;
            r_step   <= '0;
            r_leds   <= w_pat_chg;
            r_tick   <= 1'b0;
        end else if (w_wrap) begin
            r_step   <= w_step_nxt;
            r_leds   <= w_pat_step;
            r_tick   <= 1'b1;
        end else begin
            r_tick   <= 1'b0;
        end
    end

    assign leds = r_leds;
    assign tick = r_tick;

endmodule

// File: tb/tb_tail_light_driver.sv
// Directed bench for tail_light_driver with a cycle-level reference model feeding a scoreboard.
module tb_tail_light_driver;

    localparam int DIV = 4;
    localparam int N   = 3;

    typedef struct {
        logic [N-1:0] leds;
        logic         tick;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic [N-1:0] leds;
    logic         tick;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    // Reference model state
    logic [1:0]   m_mode_q;
    int           m_div;
    int           m_step;
    logic [N-1:0] m_leds;

    int tick_cnt;

    tail_light_driver #(.TICK_DIV(DIV), .LED_N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .leds (leds),
        .tick (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_pat(input logic [1:0] m, input int s);
        logic [N-1:0] p;
        case (m)
            2'b01: p = {N{1'b1}};
            2'b10: begin
                p = '0;
                if (s < N) for (int i = 0; i <= s; i++) p[i] = 1'b1;
            end
            2'b11: p = (s == 0) ? {N{1'b1}} : '0;
            default: p = '0;
        endcase
        return p;
    endfunction

    task automatic model_reset();
        m_mode_q = 2'b00;
        m_div    = 0;
        m_step   = 0;
        m_leds   = '0;
    endtask

    task automatic model_edge(output exp_t e);
        if (mode != m_mode_q) begin
            m_mode_q = mode;
            m_div    = 0;
            m_step   = 0;
            m_leds   = ref_pat(mode, 0);
            e.tick   = 1'b0;
        end else if (m_div == DIV - 1) begin
            m_div = 0;
            if (m_mode_q == 2'b10)      m_step = (m_step == N) ? 0 : m_step + 1;
            else if (m_mode_q == 2'b11) m_step = (m_step == 0) ? 1 : 0;
            else                        m_step = 0;
            m_leds = ref_pat(m_mode_q, m_step);
            e.tick = 1'b1;
        end else begin
            m_div  = m_div + 1;
            e.tick = 1'b0;
        end
        e.leds = m_leds;
    endtask

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // One clock: predict, push, let the edge happen, pop and compare.
    task automatic cycn(input int n, input string tag);
        exp_t e, g;
        for (int k = 0; k < n; k++) begin
            model_edge(e);
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (tick === 1'b1) tick_cnt++;
            g = sb.pop_front();
            chk({tag, "_leds"}, 8'(leds), 8'(g.leds));
            chk({tag, "_tick"}, 8'(tick), 8'(g.tick));
        end
    endtask

    initial begin
        rst  = 1'b1;
        mode = 2'b00;
        model_reset();
        #12;
        chk("rst_leds", 8'(leds), 8'd0);
        chk("rst_tick", 8'(tick), 8'd0);
        #10;
        rst = 1'b0;

        // 1: idle, tick every DIV cycles
        tick_cnt = 0;
        cycn(20, "off");
        chk("off_tick_count", 8'(tick_cnt), 8'd5);

        // 2: brake steady
        mode = 2'b01;
        cycn(1, "brake1");
        chk("brake_on", 8'(leds), 8'b111);
        cycn(40, "brake");
        chk("brake_hold", 8'(leds), 8'b111);

        // 3: turn sweep
        mode = 2'b00;
        cycn(1, "to_off");
        mode = 2'b10;
        cycn(1, "turn");
        chk("turn_e1", 8'(leds), 8'b001);
        cycn(4, "turn");
        chk("turn_e5", 8'(leds), 8'b011);
        cycn(4, "turn");
        chk("turn_e9", 8'(leds), 8'b111);
        cycn(4, "turn");
        chk("turn_e13", 8'(leds), 8'b000);
        cycn(4, "turn");
        chk("turn_e17", 8'(leds), 8'b001);
        cycn(16, "turn_p2");
        chk("turn_e33", 8'(leds), 8'b001);

        // 4: hazard blink
        mode = 2'b00;
        cycn(1, "to_off");
        mode = 2'b11;
        cycn(1, "haz");
        chk("haz_e1", 8'(leds), 8'b111);
        cycn(4, "haz");
        chk("haz_e5", 8'(leds), 8'b000);
        chk("haz_e5_tick", 8'(tick), 8'd1);
        cycn(4, "haz");
        chk("haz_e9", 8'(leds), 8'b111);
        chk("haz_e9_tick", 8'(tick), 8'd1);

        // 5: turn -> hazard on the cycle the prescaler would wrap
        mode = 2'b00;
        cycn(1, "to_off");
        mode = 2'b10;
        cycn(12, "sw_turn");
        chk("sw_pre", 8'(leds), 8'b111);
        mode = 2'b11;
        cycn(1, "sw_haz");
        chk("sw_leds", 8'(leds), 8'b111);
        chk("sw_tick", 8'(tick), 8'd0);
        cycn(3, "sw_haz");
        chk("sw_hold", 8'(leds), 8'b111);
        cycn(1, "sw_haz");
        chk("sw_toggle", 8'(leds), 8'b000);
        chk("sw_toggle_tick", 8'(tick), 8'd1);

        // 6: async reset mid-sweep with turn held through release
        mode = 2'b00;
        cycn(1, "to_off");
        mode = 2'b10;
        cycn(5, "pre_rst");
        chk("pre_rst", 8'(leds), 8'b011);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_leds", 8'(leds), 8'd0);
        chk("rst_async_tick", 8'(tick), 8'd0);
        @(posedge clk);
        #1;
        chk("rst_held", 8'(leds), 8'd0);
        rst = 1'b0;
        model_reset();
        cycn(1, "post_rst");
        chk("post_rst_e1", 8'(leds), 8'b001);
        cycn(4, "post_rst");
        chk("post_rst_e5", 8'(leds), 8'b011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: sequence did not complete");
        $fatal(1, "timeout");
    end

endmodule
